alu_operand_stage: RTL and testbench

- Pipeline stage directly upstream of the ALU.
- Accepts decoded ops from the ID stage over a valid/ready handshake and selects operand 1 and operand 2 from rs1/pc/zero and rs2/imm/4.
- Registers the selected operands, the 4-bit ALU ctrl code and the writeback tag, and presents them to the ALU/EX consumer.
- A 2-entry skid buffer sustains 1 op/cycle under back-pressure with a registered in_ready.

---
 rtl/alu_operand_stage.sv | 142 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand-select stage in front of the ALU: picks in1/in2, registers them with ctrl/tag behind a 2-entry skid buffer.
// Optional perf counters (perf_ops, perf_stall) are enabled by defining ALU_OPERAND_STAGE_PERF_EN.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [1:0]       in_src1_sel,
  input  logic [1:0]       in_src2_sel,
  input  logic [3:0]       in_alu_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_ctrl,
  output logic [WIDTH-1:0] out_in1,
  output logic [WIDTH-1:0] out_in2,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_OPERAND_STAGE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
`endif
);

  localparam int EW = 2 * WIDTH + 4 + TAG_W;

  logic [WIDTH-1:0] sel1;
  logic [WIDTH-1:0] sel2;
  logic [EW-1:0]    in_entry;
  logic [EW-1:0]    main_q, main_d;
  logic [EW-1:0]    skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             in_fire;
  logic             out_fire;

  always_comb begin
    sel1 = '0;
    case (in_src1_sel)
      2'd0:    sel1 = in_rs1;
      2'd1:    sel1 = in_pc;
      default: sel1 = '0;
    endcase
  end

  always_comb begin
    sel2 = in_rs2;
    case (in_src2_sel)
      2'd1:    sel2 = in_imm;
      2'd2:    sel2 = WIDTH'(4);
      default: sel2 = in_rs2;
    endcase
  end

  // Entry layout: {ctrl, tag, in1, in2}
  assign in_entry = {in_alu_ctrl, in_tag, sel1, sel2};

  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_alu_ctrl = main_q[EW-1 -: 4];
  assign out_tag      = main_q[2*WIDTH +: TAG_W];
  assign out_in1      = main_q[WIDTH +: WIDTH];
  assign out_in2      = main_q[0 +: WIDTH];

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      // Redirect kills everything; data regs keep stale contents behind cleared valids.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (in_fire) begin
        main_d   = in_entry;
        main_v_d = 1'b1;
      end
    end else if (!skid_v_q) begin
      if (in_fire && out_fire) begin
        main_d = in_entry;
      end else if (in_fire) begin
        skid_d   = in_entry;
        skid_v_d = 1'b1;
      end else if (out_fire) begin
        main_v_d = 1'b0;
      end
    end else if (out_fire) begin
      main_d   = skid_q;
      skid_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

`ifdef ALU_OPERAND_STAGE_PERF_EN
  logic [31:0] ops_q, ops_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    ops_d   = out_fire ? ops_q + 32'd1 : ops_q;
    stall_d = (out_valid && !out_ready) ? stall_q + 32'd1 : stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      ops_q   <= ops_d;
      stall_q <= stall_d;
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: pass-through, selects, back-pressure, throughput, flush, async reset.
module tb_alu_operand_stage;

  localparam int WIDTH = 32;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [1:0]       in_src1_sel, in_src2_sel;
  logic [3:0]       in_alu_ctrl;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_alu_ctrl;
  logic [WIDTH-1:0] out_in1, out_in2;
  logic [TAG_W-1:0] out_tag;
`ifdef ALU_OPERAND_STAGE_PERF_EN
  logic [31:0]      perf_ops, perf_stall;
`endif

  int compared = 0;
  int mismatched = 0;

  alu_operand_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
    .in_alu_ctrl(in_alu_ctrl), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_in1(out_in1), .out_in2(out_in2),
    .out_tag(out_tag)
`ifdef ALU_OPERAND_STAGE_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] rs1,
                       input logic [WIDTH-1:0] rs2, input logic [WIDTH-1:0] imm,
                       input logic [1:0] s1, input logic [1:0] s2,
                       input logic [3:0] ctrl, input logic [TAG_W-1:0] tag);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_src1_sel = s1;
    in_src2_sel = s2;
    in_alu_ctrl = ctrl;
    in_tag      = tag;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    in_src1_sel = '0; in_src2_sel = '0; in_alu_ctrl = '0; in_tag = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_in1", out_in1, 0);
    check("rst_in2", out_in2, 0);
    check("rst_ctrl", out_alu_ctrl, 0);
    check("rst_tag", out_tag, 0);
    @(negedge clk) rst = 1'b0;
    step();

    // Single op pass-through: pc + imm
    out_ready = 1'b1;
    drive(32'h8000_0000, 32'h0, 32'h0, 32'h10, 2'd1, 2'd1, 4'h0, 6'h25);
    check("t1_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t1_out_valid", out_valid, 1);
    check("t1_in1", out_in1, 32'h8000_0000);
    check("t1_in2", out_in2, 32'h10);
    check("t1_ctrl", out_alu_ctrl, 0);
    check("t1_tag", out_tag, 6'h25);
    step();
    check("t1_drain", out_valid, 0);

    // Zero / constant-4 select
    drive(32'h0, 32'hDEAD_BEEF, 32'h1234, 32'h99, 2'd2, 2'd2, 4'h5, 6'h03);
    step();
    in_valid = 1'b0;
    check("t2_in1_zero", out_in1, 32'h0);
    check("t2_in2_four", out_in2, 32'h4);
    check("t2_ctrl", out_alu_ctrl, 4'h5);
    // Select code 3 on both sides: zero / rs2
    drive(32'h0, 32'h1234_5678, 32'hCAFE_F00D, 32'h99, 2'd3, 2'd3, 4'hA, 6'h3F);
    step();
    in_valid = 1'b0;
    check("t2b_in1_zero", out_in1, 32'h0);
    check("t2b_in2_rs2", out_in2, 32'hCAFE_F00D);
    check("t2b_tag", out_tag, 6'h3F);
    drive(32'h0, 32'h1234_5678, 32'hCAFE_F00D, 32'h99, 2'd0, 2'd0, 4'h1, 6'h01);
    step();
    in_valid = 1'b0;
    check("t2c_in1_rs1", out_in1, 32'h1234_5678);
    check("t2c_in2_rs2", out_in2, 32'hCAFE_F00D);
    step();
    check("t2_drain", out_valid, 0);

    // Back-pressure: A, B, C with consumer stalled
    out_ready = 1'b0;
    drive(32'h0, 32'd1, 32'h100, 32'h0, 2'd0, 2'd0, 4'h2, 6'd1);
    step();
    drive(32'h0, 32'd2, 32'h100, 32'h0, 2'd0, 2'd0, 4'h2, 6'd2);
    check("t3_ready_one", in_ready, 1);
    step();
    drive(32'h0, 32'd3, 32'h100, 32'h0, 2'd0, 2'd0, 4'h2, 6'd3);
    check("t3_full_ready", in_ready, 0);
    check("t3_A_valid", out_valid, 1);
    check("t3_A_in1", out_in1, 32'd1);
    step();
    check("t3_hold_in1", out_in1, 32'd1);
    check("t3_hold_tag", out_tag, 6'd1);
    check("t3_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    check("t3_B_valid", out_valid, 1);
    check("t3_B_in1", out_in1, 32'd2);
    check("t3_B_tag", out_tag, 6'd2);
    check("t3_B_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t3_C_valid", out_valid, 1);
    check("t3_C_in1", out_in1, 32'd3);
    check("t3_C_tag", out_tag, 6'd3);
    step();
    check("t3_drain", out_valid, 0);

    // Full throughput, 16 back-to-back ops
    for (int i = 0; i < 16; i++) begin
      drive(32'h0, 32'd100 + 32'(i), 32'h0, 32'h0, 2'd0, 2'd2, 4'h3, 6'(i));
      check("t4_in_ready", in_ready, 1);
      step();
      check("t4_out_valid", out_valid, 1);
      check("t4_in1", out_in1, 32'd100 + 32'(i));
      check("t4_in2", out_in2, 32'd4);
    end
    in_valid = 1'b0;
    step();
    check("t4_drain", out_valid, 0);

    // Flush while FULL with a waiting input
    out_ready = 1'b0;
    drive(32'h0, 32'h11, 32'h0, 32'h0, 2'd0, 2'd0, 4'h4, 6'h11);
    step();
    drive(32'h0, 32'h22, 32'h0, 32'h0, 2'd0, 2'd0, 4'h4, 6'h22);
    step();
    check("t5_full", in_ready, 0);
    drive(32'h0, 32'h33, 32'h0, 32'h0, 2'd0, 2'd0, 4'h4, 6'h33);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    check("t5_stays_empty", out_valid, 0);
    // Flush while ONE with an accepted input: input also discarded
    out_ready = 1'b0;
    drive(32'h0, 32'h44, 32'h0, 32'h0, 2'd0, 2'd0, 4'h4, 6'h04);
    step();
    drive(32'h0, 32'h55, 32'h0, 32'h0, 2'd0, 2'd0, 4'h4, 6'h05);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5b_flush_valid", out_valid, 0);
    check("t5b_flush_ready", in_ready, 1);
    step();
    check("t5b_stays_empty", out_valid, 0);

    // Async reset between edges while ONE
    drive(32'h0, 32'h66, 32'h0, 32'h0, 2'd0, 2'd0, 4'h7, 6'h06);
    step();
    in_valid = 1'b0;
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_in1", out_in1, 32'h66);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_in1", out_in1, 0);
    check("t6_rst_ctrl", out_alu_ctrl, 0);
    check("t6_rst_ready", in_ready, 1);
`ifdef ALU_OPERAND_STAGE_PERF_EN
    check("t6_perf_ops", perf_ops, 0);
    check("t6_perf_stall", perf_stall, 0);
`endif
    @(negedge clk) rst = 1'b0;
    step();
    check("t6_post_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
